// File: rtl/ghash_ctrl_fsm.sv
// GHASH sequencing controller: loads H, zeroes S, then streams AAD, CT and LEN blocks
// through the accumulate/multiply loop. Define GHASH_CTRL_ABORT_EN to add the abort input.
module ghash_ctrl_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] aad_blocks,
    input  logic [CNT_W-1:0] ct_blocks,
    input  logic             h_valid,
    input  logic             blk_valid,
`ifdef GHASH_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             blk_ready,
    output logic             h_reg_en,
    output logic             ac_clr,
    output logic             ac_reg_en,
    output logic             s_reg_en,
    output logic [1:0]       mux_sel,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_H, S_ZERO_S, S_FETCH, S_MUL, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        SEL_AAD = 2'b00,
        SEL_CT  = 2'b01,
        SEL_LEN = 2'b10
    } sel_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  aad_cnt_q, aad_cnt_d;
    logic [CNT_W-1:0]  ct_cnt_q, ct_cnt_d;
    sel_e              mux_sel_q, mux_sel_d;
    logic              abort_w;

`ifdef GHASH_CTRL_ABORT_EN
    assign abort_w = abort && (state_q != S_IDLE);
`else
    assign abort_w = 1'b0;
`endif

    // Phase is picked from the remaining counts; the LEN block always comes last.
    function automatic sel_e phase_sel(input logic [CNT_W-1:0] aad_c,
                                       input logic [CNT_W-1:0] ct_c);
        if (aad_c != '0)     return SEL_AAD;
        else if (ct_c != '0) return SEL_CT;
        else                 return SEL_LEN;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            aad_cnt_q <= '0;
            ct_cnt_q  <= '0;
            mux_sel_q <= SEL_AAD;
        end else begin
            state_q   <= state_d;
            aad_cnt_q <= aad_cnt_d;
            ct_cnt_q  <= ct_cnt_d;
            mux_sel_q <= mux_sel_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        aad_cnt_d = aad_cnt_q;
        ct_cnt_d  = ct_cnt_q;
        mux_sel_d = mux_sel_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    aad_cnt_d = aad_blocks;
                    ct_cnt_d  = ct_blocks;
                    state_d   = S_LOAD_H;
                end
            end
            S_LOAD_H: begin
                if (h_valid) state_d = S_ZERO_S;
            end
            S_ZERO_S: begin
                state_d   = S_FETCH;
                mux_sel_d = phase_sel(aad_cnt_q, ct_cnt_q);
            end
            S_FETCH: begin
                if (blk_valid) begin
                    if (mux_sel_q == SEL_AAD && aad_cnt_q != '0)
                        aad_cnt_d = aad_cnt_q - CNT_W'(1);
                    else if (mux_sel_q == SEL_CT && ct_cnt_q != '0)
                        ct_cnt_d = ct_cnt_q - CNT_W'(1);
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (mux_sel_q == SEL_LEN) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_FETCH;
                    mux_sel_d = phase_sel(aad_cnt_q, ct_cnt_q);
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                mux_sel_d = SEL_AAD;
            end
            default: begin
                state_d   = S_IDLE;
                mux_sel_d = SEL_AAD;
            end
        endcase
        // Abort wins over anything else, including a handshake this cycle.
        if (abort_w) begin
            state_d   = S_IDLE;
            aad_cnt_d = '0;
            ct_cnt_d  = '0;
            mux_sel_d = SEL_AAD;
        end
    end

    always_comb begin
        blk_ready = 1'b0;
        h_reg_en  = 1'b0;
        ac_clr    = 1'b0;
        ac_reg_en = 1'b0;
        s_reg_en  = 1'b0;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        unique case (state_q)
            S_LOAD_H: begin
                h_reg_en = h_valid;
                ac_clr   = h_valid;
            end
            S_ZERO_S: s_reg_en = 1'b1;
            S_FETCH: begin
                blk_ready = 1'b1;
                ac_reg_en = blk_valid && !abort_w;
            end
            S_MUL:   s_reg_en = 1'b1;
            S_DONE:  done     = 1'b1;
            default: ;
        endcase
        if (abort_w) ac_clr = 1'b1;
    end

    assign mux_sel = mux_sel_q;

endmodule

// File: tb/tb_ghash_ctrl_fsm.sv
// Self-checking bench for ghash_ctrl_fsm: table-driven full runs plus hand-written
// reset and abort sequences (abort only when GHASH_CTRL_ABORT_EN is defined).
module tb_ghash_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] aad_blocks = '0;
    logic [15:0] ct_blocks = '0;
    logic        h_valid = 1'b0;
    logic        blk_valid = 1'b0;
    logic        abort = 1'b0;
    logic        blk_ready, h_reg_en, ac_clr, ac_reg_en, s_reg_en, busy, done;
    logic [1:0]  mux_sel;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ghash_ctrl_fsm #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .aad_blocks (aad_blocks),
        .ct_blocks  (ct_blocks),
        .h_valid    (h_valid),
        .blk_valid  (blk_valid),
`ifdef GHASH_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .blk_ready  (blk_ready),
        .h_reg_en   (h_reg_en),
        .ac_clr     (ac_clr),
        .ac_reg_en  (ac_reg_en),
        .s_reg_en   (s_reg_en),
        .mux_sel    (mux_sel),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int          aad;
        int          ct;
        int          h_low;      // cycles h_valid stays low after start
        logic [31:0] pat;        // blk_valid per FETCH cycle, bit 0 first
        int          start_at;   // cycle of a spurious start pulse (0 = none)
        int          exp_done;
        int          exp_ac;
        int          exp_s;
        int          exp_h_cyc;
    } vec_t;

    typedef struct {
        int done_cyc;
        int done_cnt;
        int ac_cnt;
        int s_cnt;
        int h_cnt;
        int h_cyc;
        int clr_cnt;
        int mux_err;
        int viol;
        int end_busy;
        int end_mux;
    } res_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one start..done transaction and collects what was observed each cycle.
    task automatic run_vec(input vec_t v, output res_t r);
        int fidx;
        int exp_mux;
        r = '{done_cyc: -1, end_busy: 1, end_mux: 3, default: 0};
        fidx = 0;
        @(negedge clk);
        aad_blocks = 16'(v.aad);
        ct_blocks  = 16'(v.ct);
        start      = 1'b1;
        h_valid    = (v.h_low == 0);
        blk_valid  = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = (cyc == v.start_at);
            if (start) begin
                aad_blocks = 16'd7;
                ct_blocks  = 16'd7;
            end
            h_valid = (cyc > v.h_low);
            if (blk_ready && fidx < 32) begin
                blk_valid = v.pat[fidx];
                fidx++;
            end else begin
                blk_valid = 1'b0;
            end
            #1;
            if (ac_reg_en) begin
                exp_mux = (r.ac_cnt < v.aad) ? 0 : (r.ac_cnt < v.aad + v.ct) ? 1 : 2;
                if (int'(mux_sel) != exp_mux) r.mux_err++;
                r.ac_cnt++;
            end
            if (s_reg_en) r.s_cnt++;
            if (ac_clr)   r.clr_cnt++;
            if (h_reg_en) begin
                r.h_cnt++;
                r.h_cyc = cyc;
            end
            if ((ac_reg_en && s_reg_en) || mux_sel == 2'b11 ||
                (blk_ready && !blk_valid && (ac_reg_en || s_reg_en || h_reg_en || ac_clr)) ||
                (ac_reg_en && !blk_ready) || (done && !busy))
                r.viol++;
            if (done) begin
                r.done_cnt++;
                r.done_cyc = cyc;
            end
            if (r.done_cnt > 0 && cyc >= r.done_cyc + 3) begin
                r.end_busy = int'(busy);
                r.end_mux  = int'(mux_sel);
                break;
            end
        end
        start     = 1'b0;
        blk_valid = 1'b0;
    endtask

    vec_t vecs[8];
    res_t res;
    int   done_seen;

    initial begin
        vecs[0] = '{2, 3, 0, 32'hFFFF_FFFF, 0, 15, 6, 7, 1};  // nominal
        vecs[1] = '{0, 0, 0, 32'hFFFF_FFFF, 0,  5, 1, 2, 1};  // LEN only
        vecs[2] = '{1, 0, 0, 32'hFFFF_FFFF, 0,  7, 2, 3, 1};
        vecs[3] = '{0, 2, 0, 32'hFFFF_FFFF, 0,  9, 3, 4, 1};
        vecs[4] = '{3, 1, 0, 32'hFFFF_FFFF, 0, 13, 5, 6, 1};
        vecs[5] = '{2, 3, 4, 32'hFFFF_FFFF, 0, 19, 6, 7, 5};  // H late by 4
        vecs[6] = '{2, 3, 0, 32'hFFFF_FFF9, 0, 17, 6, 7, 1};  // blk_valid 1,0,0,1
        vecs[7] = '{2, 3, 0, 32'hFFFF_FFFF, 4, 15, 6, 7, 1};  // start during MUL

        #1;
        check("reset_outputs", int'({blk_ready, h_reg_en, ac_clr, ac_reg_en, s_reg_en, busy, done, mux_sel}), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], res);
            check($sformatf("v%0d_done_cycle", i), res.done_cyc, vecs[i].exp_done);
            check($sformatf("v%0d_done_count", i), res.done_cnt, 1);
            check($sformatf("v%0d_ac_reg_en", i), res.ac_cnt, vecs[i].exp_ac);
            check($sformatf("v%0d_s_reg_en", i), res.s_cnt, vecs[i].exp_s);
            check($sformatf("v%0d_h_reg_en", i), res.h_cnt, 1);
            check($sformatf("v%0d_h_cycle", i), res.h_cyc, vecs[i].exp_h_cyc);
            check($sformatf("v%0d_ac_clr", i), res.clr_cnt, 1);
            check($sformatf("v%0d_mux_order", i), res.mux_err, 0);
            check($sformatf("v%0d_rules", i), res.viol, 0);
            check($sformatf("v%0d_end_busy", i), res.end_busy, 0);
            check($sformatf("v%0d_end_mux", i), res.end_mux, 0);
        end

        // Reset during FETCH of block 2 (cycle 5 of a 2/3 run).
        @(negedge clk);
        aad_blocks = 16'd2;
        ct_blocks  = 16'd3;
        start      = 1'b1;
        h_valid    = 1'b1;
        blk_valid  = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("pre_reset_fetch", int'({blk_ready, mux_sel}), 3'b100);
        rst = 1'b0;
        #1;
        check("midrun_reset_outputs", int'({blk_ready, h_reg_en, ac_clr, ac_reg_en, s_reg_en, busy, done, mux_sel}), 0);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("post_reset_idle", done_seen, 0);
        blk_valid = 1'b0;

`ifdef GHASH_CTRL_ABORT_EN
        // Abort together with a handshake in the first FETCH cycle.
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        blk_valid = 1'b1;
        abort     = 1'b1;
        #1;
        check("abort_ac_reg_en", int'(ac_reg_en), 0);
        check("abort_ac_clr", int'(ac_clr), 1);
        @(negedge clk);
        abort     = 1'b0;
        blk_valid = 1'b0;
        #1;
        check("abort_idle", int'(busy), 0);
        done_seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_vec(vecs[0], res);
        check("abort_rerun_done_cycle", res.done_cyc, 15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
